// File: rtl/alu_4_pkg.sv
// alu_4_pkg -- shared constants for the 4-bit registered ALU.
//   WIDTH_DEFAULT : the only supported operand/result width.
//   ARITH / LOGIC : values of the S2 mode select.
//   OP_*          : the eight {S2,S1,S0} operation codes.
//   y_sel_e       : arithmetic-mode encoding of {S1,S0} for the adder's Y operand.
package alu_4_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int DATA_W        = WIDTH_DEFAULT;

  localparam logic ARITH = 1'b0;
  localparam logic LOGIC = 1'b1;

  localparam logic [2:0] OP_INC_A = 3'b000; // A + Cin
  localparam logic [2:0] OP_ADD   = 3'b001; // A + B + Cin
  localparam logic [2:0] OP_SUB   = 3'b010; // A + ~B + Cin
  localparam logic [2:0] OP_DEC_A = 3'b011; // A + 1111 + Cin
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_NOT_A = 3'b111;

  typedef enum logic [1:0] {
    Y_ZERO = 2'b00,
    Y_B    = 2'b01,
    Y_NOTB = 2'b10,
    Y_ONES = 2'b11
  } y_sel_e;

endpackage

// File: rtl/alu_4_adder.sv
// alu_4_adder -- 4-bit ripple-carry adder.
//   a, y   : addends
//   cin    : carry into bit 0
//   sum    : truncated 4-bit sum
//   cout   : carry out of bit 3
//   c_msb  : carry into bit 3 (for signed-overflow detection)
module alu_4_adder
  import alu_4_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] y,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);

  logic [DATA_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (a[i] & y[i]) | (c[i] & (a[i] ^ y[i]));
  end

  assign cout  = c[DATA_W];
  assign c_msb = c[DATA_W-1];

endmodule

// File: rtl/alu_4.sv
// alu_4 -- 4-bit ALU with a one-cycle registered result.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : S2/S1/S0/Cin/A/B valid this cycle
//   S2         : 0 arithmetic, 1 logic; S1,S0 select the operation in the mode
//   Cin        : carry in (arithmetic only)
//   A, B       : operands
//   G, Cout    : registered result and carry out
//   out_valid  : G/Cout (and flags) were updated by the previous cycle's input
//   Z, N, V    : zero / negative / signed-overflow flags, present only when
//                the ALU_4_FLAGS_EN macro is defined
// Handshake: valid-only, no backpressure. Every cycle with in_valid=1 is
// accepted; its result appears on the next cycle with out_valid=1. With
// in_valid=0 the outputs hold and out_valid drops. rst wins over in_valid.
module alu_4
  import alu_4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             Cout,
  output logic             out_valid
`ifdef ALU_4_FLAGS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             V
`endif
);

  if (WIDTH != 4) begin : g_bad_width
    $error("alu_4: only WIDTH=4 is supported");
  end

  logic [2:0]       op;
  y_sel_e           y_sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             c_msb;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] g_next;
  logic             cout_next;
  logic             v_next;

  assign op    = {S2, S1, S0};
  assign y_sel = y_sel_e'({S1, S0});

  always_comb begin
    y = '0;
    case (y_sel)
      Y_ZERO:  y = '0;
      Y_B:     y = B;
      Y_NOTB:  y = ~B;
      Y_ONES:  y = '1;
      default: y = '0;
    endcase
  end

  alu_4_adder u_adder (
    .a     (A),
    .y     (y),
    .cin   (Cin),
    .sum   (sum),
    .cout  (sum_cout),
    .c_msb (c_msb)
  );

  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND:   logic_res = A & B;
      OP_OR:    logic_res = A | B;
      OP_XOR:   logic_res = A ^ B;
      OP_NOT_A: logic_res = ~A;
      default:  logic_res = '0;
    endcase
  end

  always_comb begin
    g_next    = sum;
    cout_next = sum_cout;
    v_next    = c_msb ^ sum_cout;
    if (S2 == LOGIC) begin
      g_next    = logic_res;
      cout_next = 1'b0;
      v_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      G         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        G    <= g_next;
        Cout <= cout_next;
      end
    end
  end

`ifdef ALU_4_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Z <= 1'b1;
      N <= 1'b0;
      V <= 1'b0;
    end else if (in_valid) begin
      Z <= (g_next == '0);
      N <= g_next[WIDTH-1];
      V <= v_next;
    end
  end
`else
  // Overflow only feeds the flag registers; keep it visibly unused here.
  logic unused_v;
  assign unused_v = v_next;
`endif

endmodule

// File: tb/tb_alu_4.sv
// tb_alu_4 -- self-checking bench for alu_4 (flag checks enabled with
// ALU_4_FLAGS_EN). Expected results are queued as {G,Cout,Z,N,V} when an
// operation is driven and popped when out_valid is expected.
module tb_alu_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       S2, S1, S0, Cin;
  logic [3:0] A, B;
  logic [3:0] G;
  logic       Cout;
  logic       out_valid;
`ifdef ALU_4_FLAGS_EN
  logic       Z, N, V;
`endif

  always #5 clk = ~clk;

  alu_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .S2        (S2),
    .S1        (S1),
    .S0        (S0),
    .Cin       (Cin),
    .A         (A),
    .B         (B),
    .G         (G),
    .Cout      (Cout),
    .out_valid (out_valid)
`ifdef ALU_4_FLAGS_EN
    ,
    .Z         (Z),
    .N         (N),
    .V         (V)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  localparam logic [7:0] RESET_EXP = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};

  typedef struct {
    logic [2:0] s;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic       cout;
    logic       v;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: integer sum plus sign-based overflow test.
  function automatic logic [7:0] model(input logic [2:0] s, input logic cin,
                                       input logic [3:0] a, input logic [3:0] b);
    logic [3:0] y, g;
    logic       c, v;
    int         total;
    y = 4'd0; g = 4'd0; c = 1'b0; v = 1'b0;
    if (s[2] == 1'b0) begin
      case (s[1:0])
        2'b00: y = 4'b0000;
        2'b01: y = b;
        2'b10: y = ~b;
        default: y = 4'b1111;
      endcase
      total = int'(a) + int'(y) + int'(cin);
      g = total[3:0];
      c = total[4];
      v = (a[3] == y[3]) && (g[3] != a[3]);
    end else begin
      case (s[1:0])
        2'b00: g = a & b;
        2'b01: g = a | b;
        2'b10: g = a ^ b;
        default: g = ~a;
      endcase
    end
    return {g, c, (g == 4'd0), g[3], v};
  endfunction

  task automatic compare_out(input string name, input logic [7:0] e);
    check({name, "_g"}, {4'b0, G}, {4'b0, e[7:4]});
    check({name, "_cout"}, {7'b0, Cout}, {7'b0, e[3]});
`ifdef ALU_4_FLAGS_EN
    check({name, "_znv"}, {5'b0, Z, N, V}, {5'b0, e[2:0]});
`endif
  endtask

  task automatic drive_op(input logic [2:0] s, input logic cin, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    {S2, S1, S0} = s;
    Cin = cin; A = a; B = b;
    exp_q.push_back(e);
  endtask

  task automatic collect(input string name);
    logic [7:0] e;
    @(posedge clk);
    #1;
    check({name, "_ov"}, {7'b0, out_valid}, 8'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      e = exp_q.pop_front();
      compare_out(name, e);
      last_exp = e;
    end
  endtask

  task automatic idle(input int n, input string name);
    @(negedge clk);
    in_valid = 1'b0;
    A = 4'($urandom_range(0, 15));
    B = 4'($urandom_range(0, 15));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check({name, "_ov"}, {7'b0, out_valid}, 8'd0);
      compare_out({name, "_hold"}, last_exp);
    end
  endtask

  // Reset asserted together with a valid op: the op must be dropped.
  task automatic reset_with_op(input string name);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    {S2, S1, S0} = 3'b001; Cin = 1'b1; A = 4'b0101; B = 4'b0011;
    @(posedge clk);
    #1;
    check({name, "_ov"}, {7'b0, out_valid}, 8'd0);
    compare_out(name, RESET_EXP);
    last_exp = RESET_EXP;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 4'b1111, 4'b0001, 4'b1111, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 1'b1, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0};
    vecs[4]  = '{3'b010, 1'b0, 4'b1111, 4'b0001, 4'b1101, 1'b1, 1'b0};
    vecs[5]  = '{3'b010, 1'b1, 4'b1111, 4'b0001, 4'b1110, 1'b1, 1'b0};
    vecs[6]  = '{3'b011, 1'b0, 4'b1111, 4'b0001, 4'b1110, 1'b1, 1'b0};
    vecs[7]  = '{3'b011, 1'b1, 4'b1111, 4'b0001, 4'b1111, 1'b1, 1'b0};
    vecs[8]  = '{3'b100, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 1'b1, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 1'b0, 4'b1111, 4'b0001, 4'b1111, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 1'b1, 4'b1111, 4'b0001, 4'b1111, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 1'b0, 4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0};
    vecs[13] = '{3'b110, 1'b1, 4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0};
    vecs[14] = '{3'b111, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[16] = '{3'b001, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0;
    {S2, S1, S0} = 3'b000; Cin = 1'b0; A = 4'd0; B = 4'd0;
    last_exp = RESET_EXP;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ov", {7'b0, out_valid}, 8'd0);
    compare_out("reset", RESET_EXP);
    @(negedge clk);
    rst = 1'b0;

    // Spec vectors, back-to-back with in_valid held high.
    for (int i = 0; i < 17; i++) begin
      drive_op(vecs[i].s, vecs[i].cin, vecs[i].a, vecs[i].b,
               {vecs[i].g, vecs[i].cout, (vecs[i].g == 4'd0), vecs[i].g[3], vecs[i].v});
      collect($sformatf("vec%0d", i));
    end

    idle(3, "idle_a");

    // Random full-throughput stream against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] s;
      logic       c;
      logic [3:0] a, b;
      s = 3'($urandom_range(0, 7));
      c = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      drive_op(s, c, a, b, model(s, c, a, b));
      collect($sformatf("rnd%0d", i));
    end

    // Reset mid-stream drops the in-flight op; next valid is normal.
    reset_with_op("rst_mid");
    idle(3, "idle_b");
    drive_op(3'b010, 1'b1, 4'b0011, 4'b0101, model(3'b010, 1'b1, 4'b0011, 4'b0101));
    collect("post_rst_a");
    drive_op(3'b001, 1'b0, 4'b1000, 4'b1000, model(3'b001, 1'b0, 4'b1000, 4'b1000));
    collect("post_rst_b");
    reset_with_op("rst_idle");
    drive_op(3'b110, 1'b0, 4'b1010, 4'b0110, model(3'b110, 1'b0, 4'b1010, 4'b0110));
    collect("post_rst_c");
    idle(2, "idle_c");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
